// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: state and owner encodings shared by the memory arbiter files
package unified_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/unified_mem_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin picker, req[0]=fetch, req[1]=data
module rr_arb2
  import unified_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       owner
);
  always_comb owner = &req ? ~last_owner : (req[1] ? OWN_D : OWN_I);
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one memory port between fetch and load/store, one transaction at a time
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);
  state_e            state_q, state_d;
  logic              owner_q, owner_d, last_q, last_d, pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd;
  logic [31:0]       cnt_q, cnt_d;
  logic              expired, done, gnt, fin;
  rr_arb2 u_arb (.req({d_req, i_req}), .last_owner(last_q), .owner(pick));
  always_comb begin
    expired = TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1) && !mem_rvalid;
    done    = mem_rvalid || expired;
    gnt     = !rst && state_q == REQ && mem_ready;
    fin     = !rst && state_q == RESP && done;
    rd      = (fin && mem_rvalid && we_q == 4'd0) ? mem_rdata : '0;
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && (i_req || d_req)) begin
      state_d = REQ;
      owner_d = pick;
      last_d  = pick;
      addr_d  = pick == OWN_D ? d_addr : i_addr;
      we_d    = pick == OWN_D ? d_we : 4'd0;
      wdata_d = pick == OWN_D ? d_wdata : '0;
    end
    if (state_q == REQ && mem_ready) begin
      state_d = RESP;
      cnt_d   = '0;
    end
    if (state_q == RESP) begin
      state_d = done ? IDLE : RESP;
      cnt_d   = done ? cnt_q : cnt_q + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_D;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end
  assign mem_req   = state_q == REQ;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign i_gnt     = gnt && owner_q == OWN_I;
  assign d_gnt     = gnt && owner_q == OWN_D;
  assign i_rvalid  = fin && owner_q == OWN_I;
  assign d_rvalid  = fin && owner_q == OWN_D;
  assign i_rdata   = owner_q == OWN_I ? rd : '0;
  assign d_rdata   = owner_q == OWN_D ? rd : '0;
  assign bus_err   = fin && !mem_rvalid;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and randomized checks against a transaction-level model
module tb_unified_mem_arbiter;
  localparam int TO = 8;
  logic        clk = 0, rst = 1;
  logic        i_req = 0, d_req = 0, mem_ready = 0, mem_rvalid = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0]  d_we = 0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, bus_err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // transaction in flight: busy until its response or timeout; acc once memory took it
  bit          m_busy = 0, m_acc = 0, m_own = 0, m_last = 1, g_i = 0, g_d = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_we = 0;
  int          m_wait = 0;
  always @(negedge clk) begin : model
    bit gnt, fin;
    logic [31:0] rd;
    gnt = !rst && m_busy && !m_acc && mem_ready;
    fin = !rst && m_busy && m_acc && (mem_rvalid || m_wait == TO - 1);
    rd  = (fin && mem_rvalid && m_we == 0) ? mem_rdata : 32'd0;
    chk("mem_req", mem_req, m_busy && !m_acc);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_we", mem_we, m_we);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_gnt", i_gnt, gnt && !m_own);
    chk("d_gnt", d_gnt, gnt && m_own);
    chk("i_rvalid", i_rvalid, fin && !m_own);
    chk("d_rvalid", d_rvalid, fin && m_own);
    chk("i_rdata", i_rdata, m_own ? 32'd0 : rd);
    chk("d_rdata", d_rdata, m_own ? rd : 32'd0);
    chk("bus_err", bus_err, fin && !mem_rvalid);
    g_i = gnt && !m_own;
    g_d = gnt && m_own;
    if (rst) begin
      m_busy = 0; m_acc = 0; m_last = 1; m_addr = 0; m_we = 0; m_wdata = 0; m_wait = 0;
    end else if (!m_busy) begin
      if (i_req || d_req) begin
        m_own   = (i_req && d_req) ? !m_last : d_req;
        m_last  = m_own;
        m_busy  = 1;
        m_acc   = 0;
        m_addr  = m_own ? d_addr : i_addr;
        m_we    = m_own ? d_we : 4'd0;
        m_wdata = m_own ? d_wdata : 32'd0;
      end
    end else if (!m_acc) begin
      if (mem_ready) begin m_acc = 1; m_wait = 0; end
    end else if (fin) m_busy = 0;
    else m_wait++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic probe();
    @(negedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // single fetch, immediate ready and response
    i_req = 1; i_addr = 32'h100;
    probe(); chk("t1_c0_gnt", i_gnt, 0); chk("t1_c0_mreq", mem_req, 0);
    tick(); mem_ready = 1;
    probe(); chk("t1_gnt", i_gnt, 1); chk("t1_mreq", mem_req, 1);
    chk("t1_maddr", mem_addr, 32'h100); chk("t1_mwe", mem_we, 0);
    tick(); i_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
    probe(); chk("t1_rvalid", i_rvalid, 1); chk("t1_rdata", i_rdata, 32'h00500093); chk("t1_drv", d_rvalid, 0);
    tick(); mem_rvalid = 0; mem_rdata = 0;
    // data store stalled five cycles by memory
    d_req = 1; d_addr = 32'h2000; d_we = 4'b0011; d_wdata = 32'hDEADBEEF;
    tick();
    for (int k = 0; k < 5; k++) begin
      probe(); chk("t2_mreq", mem_req, 1); chk("t2_maddr", mem_addr, 32'h2000);
      chk("t2_mwe", mem_we, 4'b0011); chk("t2_mwd", mem_wdata, 32'hDEADBEEF); chk("t2_nognt", d_gnt, 0);
      tick();
    end
    mem_ready = 1;
    probe(); chk("t2_gnt", d_gnt, 1); chk("t2_mwd_rdy", mem_wdata, 32'hDEADBEEF);
    tick(); d_req = 0; d_we = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h5555;
    probe(); chk("t2_rvalid", d_rvalid, 1); chk("t2_rdata", d_rdata, 0);
    tick(); mem_rvalid = 0;
    // both held: grants alternate starting with fetch
    i_req = 1; d_req = 1; i_addr = 32'h300; d_addr = 32'h4000;
    for (int t = 0; t < 4; t++) begin
      tick(); mem_ready = 1;
      probe(); chk("rr_i_gnt", i_gnt, (t % 2) == 0); chk("rr_d_gnt", d_gnt, (t % 2) == 1);
      tick(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1000 + t;
      probe(); chk("rr_rvalid", (t % 2) == 1 ? d_rvalid : i_rvalid, 1);
      tick(); mem_rvalid = 0;
    end
    i_req = 0; d_req = 0;
    chk("pin_last_d", m_last, 1);
    // timeout with no response
    tick(); i_req = 1; i_addr = 32'h500; mem_rdata = 32'hFFFF;
    tick(); mem_ready = 1;
    probe(); chk("to_gnt", i_gnt, 1);
    tick(); i_req = 0; mem_ready = 0;
    for (int k = 1; k < TO; k++) begin
      probe(); chk("to_early_err", bus_err, 0); chk("to_early_rv", i_rvalid, 0);
      tick();
    end
    probe(); chk("to_err", bus_err, 1); chk("to_rv", i_rvalid, 1); chk("to_rdata", i_rdata, 0);
    tick();
    probe(); chk("to_idle_mreq", mem_req, 0); chk("to_idle_err", bus_err, 0);
    tick();
    // reset mid-response, then a stray late response
    d_req = 1; d_addr = 32'h600;
    tick(); mem_ready = 1;
    tick(); d_req = 0; mem_ready = 0; rst = 1;
    tick(); rst = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
    probe(); chk("rst_mreq", mem_req, 0); chk("rst_maddr", mem_addr, 0);
    chk("rst_irv", i_rvalid, 0); chk("rst_drv", d_rvalid, 0); chk("rst_drd", d_rdata, 0);
    chk("pin_idle", m_busy, 0);
    tick(); mem_rvalid = 0;
    // randomized traffic, requesters obey hold-until-grant
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom % 300) == 0;
      if (!i_req || g_i) begin i_req = ($urandom % 2) == 1; i_addr = $urandom; end
      if (!d_req || g_d) begin
        d_req = ($urandom % 2) == 1; d_addr = $urandom; d_wdata = $urandom;
        d_we = ($urandom % 2) == 1 ? 4'($urandom) : 4'd0;
      end
      mem_ready  = ($urandom % 2) == 1;
      mem_rvalid = !mem_ready && ($urandom % 3) != 0;
      mem_rdata  = $urandom;
      tick();
    end
    rst = 0; i_req = 0; d_req = 0; mem_ready = 0; mem_rvalid = 0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (I) and the data load/store requester (D) of the multi-cycle RV32 core.
- Sequences exactly one outstanding transaction at a time: arbitration, request/accept handshake, response wait, timeout.
- Sits between the core control/datapath (imem_rd / dmem_rd / dmem_we paths) and a variable-latency unified memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, max cycles waiting for mem_rvalid after accept; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request; held with stable i_addr until i_gnt.
- i_addr  input  ADDR_W  fetch address.
- i_gnt  output  1  one-cycle pulse: fetch accepted by memory.
- i_rvalid  output  1  one-cycle pulse: i_rdata valid.
- i_rdata  output  DATA_W  fetched word.
- d_req  input  1  data request; held with stable d_addr/d_we/d_wdata until d_gnt.
- d_we  input  4  byte write enables; 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_gnt  output  1  one-cycle pulse: data request accepted.
- d_rvalid  output  1  one-cycle pulse: load data valid, or store acknowledged.
- d_rdata  output  DATA_W  load data (0 for stores).
- mem_req  output  1  memory request valid.
- mem_addr  output  ADDR_W  registered request address.
- mem_we  output  4  registered byte enables.
- mem_wdata  output  DATA_W  registered store data.
- mem_ready  input  1  memory accepts the request this cycle when mem_req=1.
- mem_rvalid  input  1  response valid; exactly one per accepted transaction, reads and writes.
- mem_rdata  input  DATA_W  response data.
- bus_err  output  1  one-cycle pulse on timeout.

Behaviour:
- State machine:
  - IDLE: if any req, pick an owner, latch addr/we/wdata/owner into registers, go to REQ. With no req, stay in IDLE.
  - REQ: mem_req=1. On mem_ready, pulse the owner's gnt in the same cycle and go to RESP.
  - RESP: wait for mem_rvalid. On mem_rvalid, pulse the owner's rvalid, drive the owner's rdata from mem_rdata (d_rdata=0 if the latched we!=0), go to IDLE.
- Arbitration:
  - Two-way round-robin with a last_owner register.
  - If both request, grant the side that was not granted last.
  - If only one requests, grant it.
  - last_owner updates on entry to REQ; its reset value is D, so I wins the first tie.
- Latency: req seen in IDLE at cycle N; mem_req=1 at N+1; gnt in the same cycle as mem_ready; rvalid in the same cycle as mem_rvalid.
- Minimum single transaction: 3 cycles (IDLE, REQ, RESP with immediate ready and rvalid).
- mem_req, mem_addr, mem_we and mem_wdata are driven only from registers, with no combinational path from i_*/d_*. They stay stable while in REQ.
- Output defaults every cycle: gnt/rvalid/bus_err = 0, rdata = 0 except during the rvalid pulse.
- mem_rvalid outside RESP is ignored (stray or post-reset response). Memory must not assert rvalid in the same cycle as ready. A rvalid arriving in REQ is dropped.
- Timeout:
  - Counter clears on entry to RESP and increments each RESP cycle without rvalid.
  - When the count reaches TIMEOUT-1 with no rvalid: pulse bus_err, pulse owner rvalid with rdata=0, go to IDLE.
  - A mem_rvalid in the timeout cycle wins: normal completion, no bus_err.
- A requester dropping req before gnt is a protocol violation. The latched transaction still completes, and its gnt/rvalid are still issued.
- Reset, including mid-transaction: state=IDLE, mem_req=0, mem_addr/mem_we/mem_wdata=0, all gnt/rvalid/bus_err=0, rdata=0, counter=0, last_owner=D. Any transaction in flight is abandoned.

Decomposition:
- State encodings (IDLE/REQ/RESP) and owner encoding (OWN_I, OWN_D) go in the shared defines.vh alongside the existing control-unit constants.
- One sub-module: rr_arb2, a 2-requester round-robin picker (inputs: req[1:0], last_owner; output: owner). Purely combinational; last_owner is held in the parent.

Test Plan:
- I only, i_addr=0x100, mem_ready and mem_rvalid each 1 cycle later with rdata=0x00500093 -> i_gnt at cycle 1, i_rvalid with i_rdata=0x00500093 at cycle 2, mem_we=0.
- D store d_addr=0x2000, d_we=4'b0011, d_wdata=0xDEADBEEF -> mem_we=4'b0011, mem_wdata=0xDEADBEEF held until ready; d_rvalid with d_rdata=0.
- I and D held together for 4 transactions -> grant order I, D, I, D; no requester granted twice in a row.
- mem_ready held low for 5 cycles -> mem_req and mem_addr stable for all 5 cycles; d_gnt only on the ready cycle.
- TIMEOUT=8, mem_rvalid never asserted -> bus_err plus owner rvalid with rdata=0 exactly 8 cycles after entering RESP, then back in IDLE.
- rst asserted in RESP, then a late mem_rvalid=1 with rdata=0x1234 arrives -> mem_req=0 and outputs cleared next cycle; stray rvalid ignored, no i_rvalid/d_rvalid.
